// File: rtl/regfile_mp_sb_pkg.sv
// rf_pkg: shared register-file defaults and packed read-port slicing helper
package rf_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int ADDRESS_WIDTH = 4;
  function automatic logic [31:0] rd_slice(input logic [127:0] vec, input int i, input int w);
    return 32'(vec >> (i * w)) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: sequencer/crossbar/load-return bus into the register file
interface regfile_mp_sb_if import rf_pkg::*; #(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int NUM_RD = 2
);
  logic xb_rf_w_En;
  logic [ADDRESS_WIDTH-1:0] ps_xb_wadd;
  logic [DATA_WIDTH-1:0] xb_rf_dt;
  logic dm_rf_w_En;
  logic [ADDRESS_WIDTH-1:0] dm_rf_wadd;
  logic [DATA_WIDTH-1:0] dm_rf_dt;
  logic [NUM_RD*ADDRESS_WIDTH-1:0] ps_rf_raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rf_xb_rdata;
  logic ps_rf_lock_En;
  logic [ADDRESS_WIDTH-1:0] ps_rf_lock_add;
  logic [NUM_RD-1:0] rf_ps_busy;
  logic rf_ps_stall;
  logic rf_ps_lock_err;
  modport master (
    output xb_rf_w_En, ps_xb_wadd, xb_rf_dt, dm_rf_w_En, dm_rf_wadd, dm_rf_dt, ps_rf_raddr, ps_rf_lock_En, ps_rf_lock_add,
    input rf_xb_rdata, rf_ps_busy, rf_ps_stall, rf_ps_lock_err
  );
  modport slave (
    input xb_rf_w_En, ps_xb_wadd, xb_rf_dt, dm_rf_w_En, dm_rf_wadd, dm_rf_dt, ps_rf_raddr, ps_rf_lock_En, ps_rf_lock_add,
    output rf_xb_rdata, rf_ps_busy, rf_ps_stall, rf_ps_lock_err
  );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits for outstanding loads and double-lock error pulse
module rf_scoreboard import rf_pkg::*; #(
  parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic clk_rf,
  input  logic rst_rf,
  input  logic lock_en,
  input  logic [ADDRESS_WIDTH-1:0] lock_add,
  input  logic clr_en,
  input  logic [ADDRESS_WIDTH-1:0] clr_add,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] raddr,
  output logic [NUM_RD-1:0] busy,
  output logic lock_err
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  logic [DEPTH-1:0] busy_q, set_v, clr_v;
  assign set_v = DEPTH'(lock_en) << lock_add;
  assign clr_v = DEPTH'(clr_en) << clr_add;
  // set after clear so a freshly issued load keeps the register busy
  always_ff @(posedge clk_rf) begin
    if (rst_rf) begin
      busy_q <= '0;
      lock_err <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~clr_v) | set_v;
      lock_err <= lock_en && busy_q[lock_add] && !clr_v[lock_add];
    end
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] a;
    assign a = ADDRESS_WIDTH'(rd_slice(128'(raddr), g, ADDRESS_WIDTH));
    assign busy[g] = !rst_rf && busy_q[a] && !(BYPASS != 0 && clr_v[a]);
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read, dual-write register file with optional bypass and load scoreboard
module regfile_mp_sb import rf_pkg::*; #(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input logic clk_rf,
  input logic rst_rf,
  regfile_mp_sb_if.slave rf
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // port A is written last so it wins a same-address collision
  always_ff @(posedge clk_rf) begin
    if (rst_rf) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (rf.dm_rf_w_En) mem[rf.dm_rf_wadd] <= rf.dm_rf_dt;
      if (rf.xb_rf_w_En) mem[rf.ps_xb_wadd] <= rf.xb_rf_dt;
    end
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] a;
    assign a = ADDRESS_WIDTH'(rd_slice(128'(rf.ps_rf_raddr), g, ADDRESS_WIDTH));
    assign rf.rf_xb_rdata[g*DATA_WIDTH +: DATA_WIDTH] =
      rst_rf ? '0 :
      (BYPASS != 0 && rf.xb_rf_w_En && rf.ps_xb_wadd == a) ? rf.xb_rf_dt :
      (BYPASS != 0 && rf.dm_rf_w_En && rf.dm_rf_wadd == a) ? rf.dm_rf_dt : mem[a];
  end
  rf_scoreboard #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .NUM_RD(NUM_RD), .BYPASS(BYPASS)) u_sb (
    .clk_rf(clk_rf),
    .rst_rf(rst_rf),
    .lock_en(rf.ps_rf_lock_En),
    .lock_add(rf.ps_rf_lock_add),
    .clr_en(rf.dm_rf_w_En),
    .clr_add(rf.dm_rf_wadd),
    .raddr(rf.ps_rf_raddr),
    .busy(rf.rf_ps_busy),
    .lock_err(rf.rf_ps_lock_err)
  );
  assign rf.rf_ps_stall = |rf.rf_ps_busy;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed checks of bypass (u0) and non-bypass (u1) register files fed identical stimulus
module tb_regfile_mp_sb;
  logic clk_rf = 1'b0;
  logic rst_rf = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk_rf = ~clk_rf;
  regfile_mp_sb_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4), .NUM_RD(2)) if0 ();
  regfile_mp_sb_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4), .NUM_RD(2)) if1 ();
  regfile_mp_sb #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4), .NUM_RD(2), .BYPASS(1)) u0 (.clk_rf(clk_rf), .rst_rf(rst_rf), .rf(if0));
  regfile_mp_sb #(.DATA_WIDTH(16), .ADDRESS_WIDTH(4), .NUM_RD(2), .BYPASS(0)) u1 (.clk_rf(clk_rf), .rst_rf(rst_rf), .rf(if1));
  assign if1.xb_rf_w_En = if0.xb_rf_w_En;
  assign if1.ps_xb_wadd = if0.ps_xb_wadd;
  assign if1.xb_rf_dt = if0.xb_rf_dt;
  assign if1.dm_rf_w_En = if0.dm_rf_w_En;
  assign if1.dm_rf_wadd = if0.dm_rf_wadd;
  assign if1.dm_rf_dt = if0.dm_rf_dt;
  assign if1.ps_rf_raddr = if0.ps_rf_raddr;
  assign if1.ps_rf_lock_En = if0.ps_rf_lock_En;
  assign if1.ps_rf_lock_add = if0.ps_rf_lock_add;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_rf);
    #1;
  endtask
  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
    if0.ps_rf_raddr = {a1, a0};
  endtask
  task automatic idle();
    if0.xb_rf_w_En = 0; if0.dm_rf_w_En = 0; if0.ps_rf_lock_En = 0;
  endtask
  initial begin
    idle();
    if0.ps_xb_wadd = 0; if0.xb_rf_dt = 0; if0.dm_rf_wadd = 0; if0.dm_rf_dt = 0;
    if0.ps_rf_lock_add = 0; set_rd(0, 0);
    step(); step();
    rst_rf = 0;
    #1;
    check("rst_lock_err", {31'd0, if0.rf_ps_lock_err}, 0);
    for (int i = 0; i < 16; i++) begin
      set_rd(4'(i), 4'(15 - i));
      #1;
      check($sformatf("rst_rd_b_%0d", i), if0.rf_xb_rdata, 0);
      check($sformatf("rst_rd_nb_%0d", i), if1.rf_xb_rdata, 0);
      check($sformatf("rst_stall_%0d", i), {30'd0, if0.rf_ps_stall, if1.rf_ps_stall}, 0);
    end
    if0.xb_rf_w_En = 1; if0.ps_xb_wadd = 3; if0.xb_rf_dt = 16'hA5A5; set_rd(3, 0);
    #1;
    check("byp_same_cycle", {16'd0, if0.rf_xb_rdata[15:0]}, 32'hA5A5);
    check("nobyp_same_cycle", {16'd0, if1.rf_xb_rdata[15:0]}, 0);
    step(); idle();
    #1;
    check("byp_next_cycle", {16'd0, if0.rf_xb_rdata[15:0]}, 32'hA5A5);
    check("nobyp_next_cycle", {16'd0, if1.rf_xb_rdata[15:0]}, 32'hA5A5);
    if0.ps_rf_lock_En = 1; if0.ps_rf_lock_add = 7;
    step(); idle(); set_rd(7, 7);
    #1;
    check("r7_busy", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 4'b1111);
    if0.xb_rf_w_En = 1; if0.ps_xb_wadd = 7; if0.xb_rf_dt = 16'h1111;
    if0.dm_rf_w_En = 1; if0.dm_rf_wadd = 7; if0.dm_rf_dt = 16'h2222;
    #1;
    check("ab_fwd_a_first", {16'd0, if0.rf_xb_rdata[15:0]}, 32'h1111);
    check("ab_busy_mask", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 4'b0011);
    step(); idle();
    #1;
    check("ab_a_wins_b", if0.rf_xb_rdata, 32'h1111_1111);
    check("ab_a_wins_nb", if1.rf_xb_rdata, 32'h1111_1111);
    check("ab_busy_clr", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 0);
    if0.ps_rf_lock_En = 1; if0.ps_rf_lock_add = 5;
    step(); idle(); set_rd(0, 5);
    #1;
    check("r5_busy", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 4'b1010);
    check("r5_stall", {30'd0, if0.rf_ps_stall, if1.rf_ps_stall}, 2'b11);
    if0.dm_rf_w_En = 1; if0.dm_rf_wadd = 5; if0.dm_rf_dt = 16'hBEEF;
    #1;
    check("r5_stall_mask", {30'd0, if0.rf_ps_stall, if1.rf_ps_stall}, 2'b01);
    check("r5_fwd_b", {16'd0, if0.rf_xb_rdata[31:16]}, 32'hBEEF);
    check("r5_nofwd_nb", {16'd0, if1.rf_xb_rdata[31:16]}, 0);
    step(); idle();
    #1;
    check("r5_busy_clr", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 0);
    check("r5_stored", {16'd0, if1.rf_xb_rdata[31:16]}, 32'hBEEF);
    if0.ps_rf_lock_En = 1; if0.ps_rf_lock_add = 9;
    step();
    check("lock1_no_err", {31'd0, if0.rf_ps_lock_err}, 0);
    step(); idle(); set_rd(9, 9);
    #1;
    check("lock2_err", {30'd0, if0.rf_ps_lock_err, if1.rf_ps_lock_err}, 2'b11);
    check("lock2_busy", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 4'b1111);
    step();
    check("err_one_cycle", {30'd0, if0.rf_ps_lock_err, if1.rf_ps_lock_err}, 0);
    if0.ps_rf_lock_En = 1; if0.ps_rf_lock_add = 9;
    if0.dm_rf_w_En = 1; if0.dm_rf_wadd = 9; if0.dm_rf_dt = 16'h0909;
    step(); idle();
    #1;
    check("lock_clr_no_err", {30'd0, if0.rf_ps_lock_err, if1.rf_ps_lock_err}, 0);
    check("lock_clr_set_wins", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 4'b1111);
    check("r9_data", {16'd0, if1.rf_xb_rdata[15:0]}, 32'h0909);
    for (int i = 0; i < 16; i++) begin
      if0.xb_rf_w_En = 1; if0.ps_xb_wadd = 4'(i); if0.xb_rf_dt = 16'(16'h0100 + i);
      if0.ps_rf_lock_En = (i == 15); if0.ps_rf_lock_add = 2;
      step();
    end
    idle(); set_rd(2, 15);
    #1;
    check("fill_rd", if1.rf_xb_rdata, 32'h010F_0102);
    check("fill_busy", {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 4'b0101);
    rst_rf = 1;
    if0.xb_rf_w_En = 1; if0.ps_xb_wadd = 2; if0.xb_rf_dt = 16'hFFFF;
    if0.dm_rf_w_En = 1; if0.dm_rf_wadd = 15; if0.dm_rf_dt = 16'h2222;
    if0.ps_rf_lock_En = 1; if0.ps_rf_lock_add = 6;
    #1;
    check("in_rst_rd_b", if0.rf_xb_rdata, 0);
    check("in_rst_rd_nb", if1.rf_xb_rdata, 0);
    check("in_rst_stall", {30'd0, if0.rf_ps_stall, if1.rf_ps_stall}, 0);
    step(); rst_rf = 0; idle();
    for (int i = 0; i < 16; i++) begin
      set_rd(4'(i), 4'(i));
      #1;
      check($sformatf("post_rst_rd_%0d", i), if1.rf_xb_rdata, 0);
      check($sformatf("post_rst_busy_%0d", i), {28'd0, if0.rf_ps_busy, if1.rf_ps_busy}, 0);
    end
    check("post_rst_err", {30'd0, if0.rf_ps_lock_err, if1.rf_ps_lock_err}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
